// File: rtl/xalu_pkg.sv
// Shared op codes, nibble width and sequencer state type for the nibble-serial ALU sequencer.
package xalu_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_PASSA = 3'd4;
  localparam logic [2:0] OP_PASSB = 3'd5;
  localparam logic [2:0] OP_SHR   = 3'd6;
  localparam logic [2:0] OP_SHL   = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/xalu_nibble_seq_if.sv
// Request/result bus plus the 4-bit slice connection of xalu_nibble_seq.
// Optional XALU_SEQ_OVF_EN adds the signed-overflow flag ovf.
interface xalu_nibble_seq_if
  import xalu_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = NIBBLE_W * NIBBLES;

  logic                start;
  logic [2:0]          op;
  logic                com;
  logic                cin;
  logic [W-1:0]        a_in;
  logic [W-1:0]        b_in;
  logic                busy;
  logic                done;
  logic [W-1:0]        result;
  logic                cout;
  logic                zero;
  logic                neg_zero;
  logic                equ;
`ifdef XALU_SEQ_OVF_EN
  logic                ovf;
`endif
  logic [NIBBLE_W-1:0] slc_a;
  logic [NIBBLE_W-1:0] slc_b;
  logic [2:0]          slc_f;
  logic                slc_com;
  logic                slc_ci_left;
  logic                slc_ci_right;
  logic [NIBBLE_W-1:0] slc_d;
  logic                slc_co_left;
  logic                slc_co_right;
  logic                slc_equ;

  // master: requester together with the external slice; slave: the sequencer
  modport master (
    output start, op, com, cin, a_in, b_in,
    input  busy, done, result, cout, zero, neg_zero, equ,
    input  slc_a, slc_b, slc_f, slc_com, slc_ci_left, slc_ci_right,
    output slc_d, slc_co_left, slc_co_right, slc_equ
`ifdef XALU_SEQ_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, op, com, cin, a_in, b_in,
    output busy, done, result, cout, zero, neg_zero, equ,
    output slc_a, slc_b, slc_f, slc_com, slc_ci_left, slc_ci_right,
    input  slc_d, slc_co_left, slc_co_right, slc_equ
`ifdef XALU_SEQ_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/xalu_nib_sel.sv
// Maps the nibble counter to a physical nibble, selects slice operands and steers the carry input.
module xalu_nib_sel
  import xalu_pkg::*;
#(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned W       = NIBBLE_W * NIBBLES,
  parameter int unsigned CW      = $clog2(NIBBLES)
) (
  input  logic                active_i,
  input  logic [CW-1:0]       cnt_i,
  input  logic [2:0]          op_i,
  input  logic [W-1:0]        a_i,
  input  logic [W-1:0]        b_i,
  input  logic                cin_i,
  input  logic                co_left_i,
  input  logic                co_right_i,
  output logic [CW-1:0]       idx_o,
  output logic [NIBBLE_W-1:0] slc_a_o,
  output logic [NIBBLE_W-1:0] slc_b_o,
  output logic                slc_ci_left_o,
  output logic                slc_ci_right_o
);

  logic first;

  always_comb begin
    first          = (cnt_i == '0);
    idx_o          = (op_i == OP_SHR) ? (CW'(NIBBLES - 1) - cnt_i) : cnt_i;
    slc_a_o        = '0;
    slc_b_o        = '0;
    slc_ci_left_o  = 1'b0;
    slc_ci_right_o = 1'b0;
    if (active_i) begin
      slc_a_o = a_i[32'(idx_o) * NIBBLE_W +: NIBBLE_W];
      slc_b_o = b_i[32'(idx_o) * NIBBLE_W +: NIBBLE_W];
      // Word carry enters on the first nibble, then ripples from the previous capture
      case (op_i)
        OP_ADD, OP_SHL: slc_ci_right_o = first ? cin_i : co_left_i;
        OP_SHR:         slc_ci_left_o  = first ? cin_i : co_right_i;
        default:        ;
      endcase
    end
  end

endmodule

// File: rtl/xalu_nibble_seq.sv
// Drives a 4-bit ALU slice over NIBBLES cycles to perform word-wide operations.
// Optional XALU_SEQ_OVF_EN adds the ADD signed-overflow flag.
module xalu_nibble_seq
  import xalu_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  xalu_nibble_seq_if.slave bus
);

  localparam int unsigned W       = NIBBLE_W * NIBBLES;
  localparam int unsigned CW      = $clog2(NIBBLES);
  localparam logic [CW-1:0] LastCnt = CW'(NIBBLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic          com_q, com_d, cin_q, cin_d;
  logic [W-1:0]  work_q, work_d;
  logic          col_q, col_d, cor_q, cor_d;
  logic          equ_w_q, equ_w_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d, zero_q, zero_d, nz_q, nz_d, equ_q, equ_d;
`ifdef XALU_SEQ_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  logic          run;
  logic [CW-1:0] idx;
  logic [W-1:0]  work_nxt;
  logic          equ_nxt, cout_nxt;

  assign run = (state_q == StRun);

  xalu_nib_sel #(
    .NIBBLES(NIBBLES),
    .W      (W),
    .CW     (CW)
  ) u_nib_sel (
    .active_i      (run),
    .cnt_i         (cnt_q),
    .op_i          (op_q),
    .a_i           (a_q),
    .b_i           (b_q),
    .cin_i         (cin_q),
    .co_left_i     (col_q),
    .co_right_i    (cor_q),
    .idx_o         (idx),
    .slc_a_o       (bus.slc_a),
    .slc_b_o       (bus.slc_b),
    .slc_ci_left_o (bus.slc_ci_left),
    .slc_ci_right_o(bus.slc_ci_right)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    com_d    = com_q;
    cin_d    = cin_q;
    work_d   = work_q;
    col_d    = col_q;
    cor_d    = cor_q;
    equ_w_d  = equ_w_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    nz_d     = nz_q;
    equ_d    = equ_q;
`ifdef XALU_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif

    work_nxt = work_q;
    work_nxt[32'(idx) * NIBBLE_W +: NIBBLE_W] = bus.slc_d;
    equ_nxt  = equ_w_q & bus.slc_equ;
    case (op_q)
      OP_ADD, OP_SHL: cout_nxt = bus.slc_co_left;
      OP_SHR:         cout_nxt = bus.slc_co_right;
      default:        cout_nxt = 1'b0;
    endcase

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          op_d    = bus.op;
          com_d   = bus.com;
          cin_d   = bus.cin;
          cnt_d   = '0;
          work_d  = '0;
          col_d   = 1'b0;
          cor_d   = 1'b0;
          equ_w_d = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        work_d  = work_nxt;
        col_d   = bus.slc_co_left;
        cor_d   = bus.slc_co_right;
        equ_w_d = equ_nxt;
        cnt_d   = cnt_q + CW'(1);
        // Publish on the last capture edge so the result is visible while done is high
        if (cnt_q == LastCnt) begin
          cnt_d    = '0;
          result_d = work_nxt;
          cout_d   = cout_nxt;
          zero_d   = (work_nxt == '0);
          nz_d     = &work_nxt;
          equ_d    = equ_nxt;
`ifdef XALU_SEQ_OVF_EN
          ovf_d    = (op_q == OP_ADD) && (a_q[W-1] == b_q[W-1]) &&
                     ((work_nxt[W-1] ^ com_q) != a_q[W-1]);
`endif
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      com_q    <= 1'b0;
      cin_q    <= 1'b0;
      work_q   <= '0;
      col_q    <= 1'b0;
      cor_q    <= 1'b0;
      equ_w_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      nz_q     <= 1'b0;
      equ_q    <= 1'b0;
`ifdef XALU_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      com_q    <= com_d;
      cin_q    <= cin_d;
      work_q   <= work_d;
      col_q    <= col_d;
      cor_q    <= cor_d;
      equ_w_q  <= equ_w_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      nz_q     <= nz_d;
      equ_q    <= equ_d;
`ifdef XALU_SEQ_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy     = run;
  assign bus.done     = (state_q == StDone);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.zero     = zero_q;
  assign bus.neg_zero = nz_q;
  assign bus.equ      = equ_q;
  assign bus.slc_f    = run ? op_q : 3'd0;
  assign bus.slc_com  = run ? com_q : 1'b0;
`ifdef XALU_SEQ_OVF_EN
  assign bus.ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_xalu_nibble_seq.sv
// Self-checking bench for xalu_nibble_seq: behavioural 4-bit slice plus word-level scoreboard.
module tb_xalu_nibble_seq;
  import xalu_pkg::*;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = NIBBLE_W * NIBBLES;
  localparam int          LIM     = 40;

  typedef struct packed {
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         nz;
    logic         equ;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  xalu_nibble_seq_if #(.NIBBLES(NIBBLES)) bus ();

  xalu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural model of the external 4-bit slice
  logic [4:0] s_sum;
  logic [3:0] s_raw;
  logic       s_col, s_cor;
  always_comb begin
    s_sum = {1'b0, bus.slc_a} + {1'b0, bus.slc_b} + {4'b0, bus.slc_ci_right};
    s_raw = '0;
    s_col = 1'b0;
    s_cor = 1'b0;
    case (bus.slc_f)
      3'd0: begin s_raw = s_sum[3:0]; s_col = s_sum[4]; end
      3'd1: s_raw = bus.slc_a & bus.slc_b;
      3'd2: s_raw = bus.slc_a | bus.slc_b;
      3'd3: s_raw = bus.slc_a ^ bus.slc_b;
      3'd4: s_raw = bus.slc_a;
      3'd5: s_raw = bus.slc_b;
      3'd6: begin s_raw = {bus.slc_ci_left, bus.slc_a[3:1]}; s_cor = bus.slc_a[0]; end
      default: begin s_raw = {bus.slc_a[2:0], bus.slc_ci_right}; s_col = bus.slc_a[3]; end
    endcase
    bus.slc_d        = s_raw ^ {4{bus.slc_com}};
    bus.slc_co_left  = s_col;
    bus.slc_co_right = s_cor;
    bus.slc_equ      = (bus.slc_a == bus.slc_b);
  end

  function automatic exp_t ref_model(input logic [2:0] op, input logic com, input logic cin,
                                     input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] s;
    logic [W-1:0] r;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    case (op)
      OP_ADD:   begin
        r = s[W-1:0]; e.cout = s[W];
        e.ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      OP_SHR:   begin r = {cin, a[W-1:1]}; e.cout = a[0]; end
      default:  begin r = {a[W-2:0], cin}; e.cout = a[W-1]; end
    endcase
    e.result = r ^ {W{com}};
    e.zero   = (e.result == '0);
    e.nz     = &e.result;
    e.equ    = (a == b);
    return e;
  endfunction

  // Issue one operation, then pop the scoreboard and compare when done appears
  task automatic run_op(input logic [2:0] op, input logic com, input logic cin,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int restart_at,
                        output logic [3:0] first_a);
    exp_t e;
    int   lat;
    exp_q.push_back(ref_model(op, com, cin, a, b));
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.com = com; bus.cin = cin; bus.a_in = a; bus.b_in = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    first_a = bus.slc_a;
    while (!bus.done && lat < LIM) begin
      bus.start = (lat == restart_at);
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!bus.done) begin
      errors++;
      $display("FAIL done_timeout op=%0d: no done within %0d edges", op, LIM);
      return;
    end
    if (lat !== NIBBLES + 1) begin
      errors++; $display("FAIL latency op=%0d: got %0d edges, want %0d", op, lat, NIBBLES + 1);
    end
    checks++;
    if (bus.result !== e.result) begin
      errors++; $display("FAIL result op=%0d: got %h, want %h", op, bus.result, e.result);
    end
    checks++;
    if (bus.cout !== e.cout) begin
      errors++; $display("FAIL cout op=%0d: got %b, want %b", op, bus.cout, e.cout);
    end
    checks++;
    if (bus.zero !== e.zero) begin
      errors++; $display("FAIL zero op=%0d: got %b, want %b", op, bus.zero, e.zero);
    end
    checks++;
    if (bus.neg_zero !== e.nz) begin
      errors++; $display("FAIL neg_zero op=%0d: got %b, want %b", op, bus.neg_zero, e.nz);
    end
    checks++;
    if (bus.equ !== e.equ) begin
      errors++; $display("FAIL equ op=%0d: got %b, want %b", op, bus.equ, e.equ);
    end
`ifdef XALU_SEQ_OVF_EN
    checks++;
    if (bus.ovf !== e.ovf) begin
      errors++; $display("FAIL ovf op=%0d: got %b, want %b", op, bus.ovf, e.ovf);
    end
`endif
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse op=%0d: done=%b busy=%b after pulse, want 0 0",
               op, bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.cout, bus.zero, bus.neg_zero, bus.equ} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: busy,done,cout,zero,nz,equ=%b, want 000000",
               {bus.busy, bus.done, bus.cout, bus.zero, bus.neg_zero, bus.equ});
    end
    checks++;
    if (bus.result !== '0) begin
      errors++; $display("FAIL reset_result: got %h, want 0", bus.result);
    end
    checks++;
    if ({bus.slc_a, bus.slc_b, bus.slc_f, bus.slc_com, bus.slc_ci_left, bus.slc_ci_right}
        !== 14'b0) begin
      errors++;
      $display("FAIL reset_slc: got %h, want 0",
               {bus.slc_a, bus.slc_b, bus.slc_f, bus.slc_com, bus.slc_ci_left, bus.slc_ci_right});
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [3:0] fa;
    run_op(OP_ADD, 1'b0, 1'b0, 16'h00FF, 16'h0001, 0, fa);
    run_op(OP_ADD, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 0, fa);
    run_op(OP_ADD, 1'b0, 1'b1, 16'h7FFF, 16'h0000, 0, fa);
  endtask

  task automatic test_shr();
    logic [3:0] fa;
    run_op(OP_SHR, 1'b0, 1'b1, 16'h8001, 16'h0000, 0, fa);
    checks++;
    if (fa !== 4'h8) begin
      errors++; $display("FAIL shr_first_nibble: got %h, want 8", fa);
    end
  endtask

  task automatic test_shl_restart();
    logic [3:0] fa;
    int extra = 0;
    run_op(OP_SHL, 1'b0, 1'b0, 16'h8001, 16'h0000, 2, fa);
    checks++;
    if (fa !== 4'h1) begin
      errors++; $display("FAIL shl_first_nibble: got %h, want 1", fa);
    end
    for (int i = 0; i < NIBBLES + 3; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL restart_ignored: %0d extra busy/done cycles, want 0", extra);
    end
  endtask

  task automatic test_xor_com();
    logic [3:0] fa;
    run_op(OP_XOR, 1'b1, 1'b0, 16'h1234, 16'h1234, 0, fa);
  endtask

  task automatic test_logic();
    logic [3:0] fa;
    for (int o = 1; o <= 5; o++) begin
      run_op(3'(o), 1'(o & 1), 1'b1, 16'($urandom), 16'($urandom), 0, fa);
    end
  endtask

  task automatic test_rst_mid_run();
    logic [3:0] fa;
    int dones = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_ADD; bus.com = 1'b0; bus.cin = 1'b0;
    bus.a_in = 16'h1111; bus.b_in = 16'h2222;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL busy_in_run: got %b, want 1", bus.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
      errors++;
      $display("FAIL rst_mid_run: busy=%b done=%b result=%h, want 0 0 0000",
               bus.busy, bus.done, bus.result);
    end
    for (int i = 0; i < NIBBLES + 2; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL rst_no_done: got %0d done pulses, want 0", dones);
    end
    run_op(OP_ADD, 1'b0, 1'b0, 16'h1234, 16'h4321, 0, fa);
  endtask

  task automatic test_back_to_back();
    logic [3:0] fa;
    for (int i = 0; i < 12; i++) begin
      run_op(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
             16'($urandom), 16'($urandom), 0, fa);
    end
    run_op(OP_ADD, 1'b1, 1'b0, 16'h4000, 16'h4000, 0, fa);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.com = 1'b0; bus.cin = 1'b0;
    bus.a_in = '0; bus.b_in = '0;
    test_reset();
    test_add();
    test_shr();
    test_shl_restart();
    test_xor_com();
    test_logic();
    test_rst_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xalu_nibble_seq.md
# xalu_nibble_seq

Multi-nibble sequencer that drives one external 4-bit ALU slice over NIBBLES consecutive cycles to perform full-word operations. Sits directly upstream of the slice: latches word operands on a start handshake, presents one nibble per cycle with the correct carry or shift input, captures the slice outputs, and assembles the word result, carry-out and status flags.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit nibbles per word; W = 4*NIBBLES; minimum 2

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request; accepted only in IDLE
- op  in  3  function code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL
- com  in  1  ones'-complement output mode, forwarded to the slice
- cin  in  1  word carry/shift input
- a_in, b_in  in  W  operands
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse; result and flags updated
- result  out  W  assembled slice outputs
- cout  out  1  word carry/shift output
- zero, neg_zero, equ  out  1  result all-0, result all-1, a==b
- slc_a, slc_b  out  4  nibble operands to the slice
- slc_f  out  3  function code to the slice
- slc_com, slc_ci_left, slc_ci_right  out  1  slice controls and carry inputs
- slc_d  in  4  slice data output
- slc_co_left, slc_co_right, slc_equ  in  1  slice carry outputs and nibble compare

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 latches a_in, b_in, op, com, cin; nibble counter k=0; next state RUN.
- RUN: drive nibble k combinationally from the latched operands; at the clock edge capture slc_d into the working result nibble and slc_co_left/slc_co_right into a carry register. After the NIBBLES-th capture, go to DONE.
- Nibble order: ADD, SHL run nibble 0 first (low to high); SHR runs nibble NIBBLES-1 first (high to low); all other ops run low to high.
- Carry chaining: ADD/SHL: slc_ci_right = cin on the first nibble, then the previous slc_co_left; slc_ci_left = 0. SHR: slc_ci_left = cin on the first nibble, then the previous slc_co_right; slc_ci_right = 0. Other ops: both carry inputs = 0.
- cout: last slc_co_left for ADD/SHL; last slc_co_right for SHR; 0 for all other ops.
- equ = AND of slc_equ over all nibbles. zero/neg_zero are computed over the full W-bit result after com inversion; per-slice zero outputs are not used.
- DONE: copy working registers to result, cout and flags; done=1 for this cycle; next state IDLE unconditionally.
- start is ignored in RUN and DONE; there is no queueing.
- result and flag outputs change only on entry to DONE and hold until the next DONE.

## Timing
- Reset: state IDLE, busy=0, done=0, result=0, cout=0, zero=0, neg_zero=0, equ=0, all slc_* outputs 0, counter=0.
- Start accepted at edge T: busy is high from T+1 through T+NIBBLES; done is high in the cycle after edge T+NIBBLES; the new result is visible in that same cycle.
- Start-to-done latency: NIBBLES+1 edges. Back-to-back throughput: one operation per NIBBLES+2 cycles.
- slc_* outputs are combinational from registered state only; the path through the slice settles within one cycle.
- rst in any state: IDLE on the next edge, no done pulse, outputs return to reset values.

## Configuration
- XALU_SEQ_OVF_EN defined: adds output ovf (1 bit), updated at DONE.
  - For ADD: ovf = (a[W-1]==b[W-1]) & (sum[W-1]!=a[W-1]), where sum = result XOR {W{com}}.
  - ovf = 0 for all other ops; reset value 0.
- Not defined: port ovf and its logic are absent; all other behaviour is identical.

## Structure
- Shared package xalu_pkg contains:
  - op-code localparams OP_ADD through OP_SHL (0 through 7)
  - NIBBLE_W=4
  - FSM state typedef (IDLE, RUN, DONE)
- One natural sub-module: xalu_nib_sel. It maps the counter and op to the physical nibble index, selects slc_a/slc_b, and steers the carry into slc_ci_left or slc_ci_right.

## Test plan
- ADD a=0x00FF b=0x0001 cin=0 -> result 0x0100, cout 0, zero 0; done exactly 5 edges after start (NIBBLES=4).
- ADD a=0xFFFF b=0x0001 cin=0 -> result 0x0000, cout 1, zero 1, equ 0.
- SHR a=0x8001 cin=1 -> result 0xC000, cout 1; first slc_a presented is 0x8 (high nibble).
- SHL a=0x8001 cin=0 -> result 0x0002, cout 1; a second start pulsed during busy is ignored, producing exactly one done.
- XOR a=0x1234 b=0x1234 com=1 -> result 0xFFFF, neg_zero 1, zero 0, equ 1, cout 0.
- rst during the second RUN cycle -> busy=0 next cycle, no done pulse, result 0x0000; a fresh ADD afterwards completes normally.
